// File: rtl/traffic_light_ctrl_if.sv
// Control/status bundle between the APB register file and the traffic-light sequencer.
// The master modport is the register-file side; the slave modport is the sequencer.
interface traffic_light_ctrl_if #(
    parameter int SIZE = 32
);
    logic            mod_en;
    logic            blink_yellow;
    logic            blink_red;
    logic            profile;
    logic [SIZE-1:0] timer_0;
    logic [SIZE-1:0] timer_1;
    logic            lamp_red;
    logic            lamp_yellow;
    logic            lamp_green;
    logic [1:0]      state;
    logic            phase_done;

    modport master (
        output mod_en, blink_yellow, blink_red, profile, timer_0, timer_1,
        input  lamp_red, lamp_yellow, lamp_green, state, phase_done
    );

    modport slave (
        input  mod_en, blink_yellow, blink_red, profile, timer_0, timer_1,
        output lamp_red, lamp_yellow, lamp_green, state, phase_done
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Traffic-light sequencer: RED -> GREEN -> YELLOW -> RED with tick-based phase timing,
// plus red/yellow blink modes. All outputs are registered.
module traffic_light_ctrl #(
    parameter int SIZE        = 32,
    parameter int TICK_DIV    = 1000,
    parameter int BLINK_TICKS = 50
) (
    input  logic                 pclk,
    input  logic                 preset,
    traffic_light_ctrl_if.slave  tl
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {S_OFF, S_RED, S_GREEN, S_YELLOW, S_BLR, S_BLY} st_t;

    st_t         cur, nxt;
    logic [PW-1:0] presc, presc_d;
    logic [11:0] cnt, cnt_d;
    logic        blink_on, blink_d;
    logic        tick;
    logic        pd_d;
    logic        lr_d, ly_d, lg_d;
    logic [1:0]  state_d;

    logic [SIZE-1:0] tmr;
    logic [11:0]     g2y, r2g, y2r;

    function automatic logic [11:0] ld(input logic [11:0] d);
        return (d == 12'd0) ? 12'd0 : d - 12'd1;
    endfunction

    // Durations are sampled from the currently selected profile only when a phase is entered.
    assign tmr  = tl.profile ? tl.timer_1 : tl.timer_0;
    assign g2y  = tmr[31:20];
    assign r2g  = tmr[19:8];
    assign y2r  = {4'd0, tmr[7:0]};
    assign tick = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        nxt     = cur;
        pd_d    = 1'b0;
        cnt_d   = cnt;
        blink_d = blink_on;
        presc_d = tick ? '0 : presc + 1'b1;

        if (!tl.mod_en)             nxt = S_OFF;
        else if (tl.blink_red)      nxt = S_BLR;
        else if (tl.blink_yellow)   nxt = S_BLY;
        else begin
            case (cur)
                S_RED:    if (tick && cnt == 12'd0) begin nxt = S_GREEN;  pd_d = 1'b1; end
                S_GREEN:  if (tick && cnt == 12'd0) begin nxt = S_YELLOW; pd_d = 1'b1; end
                S_YELLOW: if (tick && cnt == 12'd0) begin nxt = S_RED;    pd_d = 1'b1; end
                default:  nxt = S_RED;
            endcase
        end

        // In-phase counting; in blink states the counter times the half-period.
        if (tick) begin
            if (cnt != 12'd0) cnt_d = cnt - 12'd1;
            else if (cur == S_BLR || cur == S_BLY) begin
                cnt_d   = 12'(BLINK_TICKS - 1);
                blink_d = !blink_on;
            end
        end

        if (nxt != cur) begin
            presc_d = '0;
            blink_d = 1'b0;
            case (nxt)
                S_RED:    cnt_d = ld(r2g);
                S_GREEN:  cnt_d = ld(g2y);
                S_YELLOW: cnt_d = ld(y2r);
                S_BLR, S_BLY: begin
                    cnt_d   = 12'(BLINK_TICKS - 1);
                    blink_d = 1'b1;
                end
                default:  cnt_d = 12'd0;
            endcase
        end
        if (nxt == S_OFF) presc_d = '0;

        lr_d    = 1'b0;
        ly_d    = 1'b0;
        lg_d    = 1'b0;
        state_d = 2'b00;
        case (nxt)
            S_RED:    begin lr_d = 1'b1;    state_d = 2'b11; end
            S_GREEN:  begin lg_d = 1'b1;    state_d = 2'b01; end
            S_YELLOW: begin ly_d = 1'b1;    state_d = 2'b10; end
            S_BLR:    begin lr_d = blink_d; state_d = 2'b11; end
            S_BLY:    begin ly_d = blink_d; state_d = 2'b10; end
            default:  state_d = 2'b00;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cur            <= S_OFF;
            presc          <= '0;
            cnt            <= 12'd0;
            blink_on       <= 1'b0;
            tl.lamp_red    <= 1'b0;
            tl.lamp_yellow <= 1'b0;
            tl.lamp_green  <= 1'b0;
            tl.state       <= 2'b00;
            tl.phase_done  <= 1'b0;
        end else begin
            cur            <= nxt;
            presc          <= presc_d;
            cnt            <= cnt_d;
            blink_on       <= blink_d;
            tl.lamp_red    <= lr_d;
            tl.lamp_yellow <= ly_d;
            tl.lamp_green  <= lg_d;
            tl.state       <= state_d;
            tl.phase_done  <= pd_d;
        end
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with TICK_DIV=4, BLINK_TICKS=2; expected per-cycle
// {state, red, yellow, green, phase_done} words are queued, then popped against the DUT.
module tb_traffic_light_ctrl;
    localparam int TD = 4;

    localparam logic [1:0] OFF = 2'b00, GRN = 2'b01, YEL = 2'b10, RED = 2'b11;
    localparam logic [2:0] L0 = 3'b000, LR = 3'b100, LY = 3'b010, LG = 3'b001;

    logic pclk = 1'b0;
    logic preset;
    int   nvec = 0;
    int   nfail = 0;
    logic [5:0] sb_q[$];

    traffic_light_ctrl_if #(.SIZE(32)) tl ();

    traffic_light_ctrl #(.SIZE(32), .TICK_DIV(TD), .BLINK_TICKS(2)) dut (
        .pclk   (pclk),
        .preset (preset),
        .tl     (tl)
    );

    always #5 pclk = ~pclk;

    // Queue n cycles of expectation (phase_done only on the first), then step and compare.
    task automatic chk(input string tag, input int n, input logic [1:0] st,
                       input logic [2:0] lamps, input logic pd_first);
        logic [5:0] exp_w, got;
        for (int i = 0; i < n; i++)
            sb_q.push_back({st, lamps, (i == 0) ? pd_first : 1'b0});
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            exp_w = sb_q.pop_front();
            got   = {tl.state, tl.lamp_red, tl.lamp_yellow, tl.lamp_green, tl.phase_done};
            nvec++;
            assert (got === exp_w) else begin
                nfail++;
                $error("FAIL %s cycle %0d: got st/rgy/pd=%b expected %b", tag, i, got, exp_w);
            end
        end
    endtask

    initial begin
        preset          = 1'b1;
        tl.mod_en       = 1'b0;
        tl.blink_red    = 1'b0;
        tl.blink_yellow = 1'b0;
        tl.profile      = 1'b0;
        tl.timer_0      = 32'h0030_0201;
        tl.timer_1      = 32'h0010_0101;
        chk("reset", 2, OFF, L0, 1'b0);
        preset = 1'b0;
        chk("idle_off", 1, OFF, L0, 1'b0);

        // Normal sequence: RED 2 ticks, GREEN 3, YELLOW 1
        tl.mod_en = 1'b1;
        chk("s1_red0", 8 , RED, LR, 1'b0);
        chk("s1_grn",  12, GRN, LG, 1'b1);
        chk("s1_yel",  4 , YEL, LY, 1'b1);
        chk("s1_red1", 8 , RED, LR, 1'b1);
        chk("s4_grn",  12, GRN, LG, 1'b1);
        chk("s4_yel",  2 , YEL, LY, 1'b1);

        // Disable mid-YELLOW, then re-enable: fresh RED without pulse
        tl.mod_en = 1'b0;
        chk("s4_off",  3 , OFF, L0, 1'b0);
        tl.mod_en = 1'b1;
        chk("s4_red",  8 , RED, LR, 1'b0);
        chk("s4_grn1", 1 , GRN, LG, 1'b1);

        // Blink red from GREEN, blink_yellow ignored under blink_red
        tl.blink_red = 1'b1;
        chk("s3_br_on",   8, RED, LR, 1'b0);
        chk("s3_br_off",  8, RED, L0, 1'b0);
        chk("s3_br_on2",  4, RED, LR, 1'b0);
        tl.blink_yellow = 1'b1;
        chk("s3_br_on3",  4, RED, LR, 1'b0);
        chk("s3_br_off2", 2, RED, L0, 1'b0);
        tl.blink_red = 1'b0;
        chk("s3_by_on",   8, YEL, LY, 1'b0);
        chk("s3_by_off",  3, YEL, L0, 1'b0);
        tl.blink_yellow = 1'b0;
        chk("s3_exit_red", 8, RED, LR, 1'b0);
        chk("s3_exit_grn", 1, GRN, LG, 1'b1);

        // Reset mid-GREEN
        chk("s5_grn", 3, GRN, LG, 1'b0);
        preset = 1'b1;
        chk("s5_rst", 1, OFF, L0, 1'b0);
        preset = 1'b0;
        chk("s5_red", 8, RED, LR, 1'b0);
        chk("s5_grn1", 1, GRN, LG, 1'b1);

        // Profile switching; durations latched at phase entry
        tl.timer_0 = 32'h0;
        chk("s2_grn",  11, GRN, LG, 1'b0);
        chk("s2_yel0", 4 , YEL, LY, 1'b1);
        chk("s2_red_a", 2, RED, LR, 1'b1);
        tl.profile = 1'b1;
        chk("s2_red_b", 2, RED, LR, 1'b0);
        chk("s2_grn1", 4 , GRN, LG, 1'b1);
        chk("s2_yel1", 4 , YEL, LY, 1'b1);
        chk("s2_red1", 4 , RED, LR, 1'b1);
        chk("s2_grn2", 1 , GRN, LG, 1'b1);

        // Extremes: zero durations act as one tick, g2y=4095 without wrap
        tl.profile = 1'b0;
        tl.timer_0 = 32'hFFF0_0000;
        chk("s6_grn",   3,         GRN, LG, 1'b0);
        chk("s6_yel0",  4,         YEL, LY, 1'b1);
        chk("s6_red0",  4,         RED, LR, 1'b1);
        chk("s6_grnmx", 4095 * TD, GRN, LG, 1'b1);
        chk("s6_yel1",  1,         YEL, LY, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
